// File: rtl/emib_read_arb.sv
// emib_read_arb: round-robin arbiter that shares one EMIB read engine between NUM_REQ requesters,
// latching the winner's request fields and returning a done/error/timeout pulse to that requester only.
module emib_read_arb #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 16,
    parameter int MAX_LEN = 256,
    parameter int TMO_W   = 12,
    parameter int TMO_CYC = 4000
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*ADDR_W-1:0] i_base_addr,
    input  logic [NUM_REQ*ADDR_W-1:0] i_offset_addr,
    input  logic [NUM_REQ*ADDR_W-1:0] i_len,
    output logic [NUM_REQ-1:0]        o_grant,
    output logic [NUM_REQ-1:0]        o_done,
    output logic [NUM_REQ-1:0]        o_err,
    output logic                      o_timeout,
    output logic                      o_rd_en,
    output logic [ADDR_W-1:0]         o_base_addr,
    output logic [ADDR_W-1:0]         o_offset_addr,
    output logic [ADDR_W-1:0]         o_len,
    output logic                      o_obj_error,
    input  logic                      i_read_done,
    input  logic                      i_read_error,
    output logic                      o_busy
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W-1:0] MAX_L = ADDR_W'(MAX_LEN);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     idx, idx_nxt, last, last_nxt, sel, cand;
    logic [TMO_W-1:0]     cnt, cnt_nxt;
    logic                 found;
    logic [NUM_REQ-1:0]   idx_oh, grant_nxt, done_nxt, err_nxt;
    logic                 timeout_nxt, rd_en_nxt, obj_error_nxt, busy_nxt;
    logic [ADDR_W-1:0]    base_nxt, offset_nxt, len_nxt, sel_len;

    // round-robin search starting just after the last served requester
    always_comb begin
        sel = '0;
        cand = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last) + i) % NUM_REQ);
            if (!found && i_req[cand]) begin
                found = 1'b1;
                sel = cand;
            end
        end
        sel_len = i_len[int'(sel)*ADDR_W +: ADDR_W];
        idx_oh = NUM_REQ'(1) << idx;
    end

    always_comb begin
        state_nxt = state;
        idx_nxt = idx;
        last_nxt = last;
        cnt_nxt = cnt;
        grant_nxt = o_grant;
        done_nxt = '0;
        err_nxt = '0;
        timeout_nxt = 1'b0;
        rd_en_nxt = 1'b0;
        obj_error_nxt = o_obj_error;
        base_nxt = o_base_addr;
        offset_nxt = o_offset_addr;
        len_nxt = o_len;
        case (state)
            IDLE: if (found) begin
                idx_nxt = sel;
                base_nxt = i_base_addr[int'(sel)*ADDR_W +: ADDR_W];
                offset_nxt = i_offset_addr[int'(sel)*ADDR_W +: ADDR_W];
                len_nxt = sel_len;
                obj_error_nxt = (sel_len == '0) || (sel_len > MAX_L);
                grant_nxt = NUM_REQ'(1) << sel;
                rd_en_nxt = 1'b1;
                state_nxt = ISSUE;
            end
            ISSUE: begin
                cnt_nxt = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                cnt_nxt = cnt + TMO_W'(1);
                // error wins over a simultaneous done; timeout only when the engine is silent
                if (i_read_error || i_read_done || cnt == TMO_LAST) begin
                    err_nxt = (i_read_error || !i_read_done) ? idx_oh : '0;
                    done_nxt = (!i_read_error && i_read_done) ? idx_oh : '0;
                    timeout_nxt = !i_read_error && !i_read_done;
                    grant_nxt = '0;
                    obj_error_nxt = 1'b0;
                    state_nxt = RELEASE;
                end
            end
            default: begin
                last_nxt = idx;
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = state_nxt != IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            idx <= '0;
            last <= IDX_W'(NUM_REQ - 1);
            cnt <= '0;
            o_grant <= '0;
            o_done <= '0;
            o_err <= '0;
            o_timeout <= 1'b0;
            o_rd_en <= 1'b0;
            o_obj_error <= 1'b0;
            o_base_addr <= '0;
            o_offset_addr <= '0;
            o_len <= '0;
            o_busy <= 1'b0;
        end else begin
            state <= state_nxt;
            idx <= idx_nxt;
            last <= last_nxt;
            cnt <= cnt_nxt;
            o_grant <= grant_nxt;
            o_done <= done_nxt;
            o_err <= err_nxt;
            o_timeout <= timeout_nxt;
            o_rd_en <= rd_en_nxt;
            o_obj_error <= obj_error_nxt;
            o_base_addr <= base_nxt;
            o_offset_addr <= offset_nxt;
            o_len <= len_nxt;
            o_busy <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_emib_read_arb.sv
// tb_emib_read_arb: directed vector table plus hand-written timeout, ISSUE-done and async-reset sequences.
module tb_emib_read_arb;
    localparam int N = 4;
    localparam int AW = 16;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic [N-1:0]  i_req = '0;
    logic [N*AW-1:0] i_base_addr = '0;
    logic [N*AW-1:0] i_offset_addr = '0;
    logic [N*AW-1:0] i_len = '0;
    logic          i_read_done = 1'b0;
    logic          i_read_error = 1'b0;
    logic [N-1:0]  o_grant, o_done, o_err;
    logic          o_timeout, o_rd_en, o_obj_error, o_busy;
    logic [AW-1:0] o_base_addr, o_offset_addr, o_len;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 i_clk = ~i_clk;

    emib_read_arb #(.NUM_REQ(N), .ADDR_W(AW), .MAX_LEN(256), .TMO_W(12), .TMO_CYC(16)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req),
        .i_base_addr(i_base_addr), .i_offset_addr(i_offset_addr), .i_len(i_len),
        .o_grant(o_grant), .o_done(o_done), .o_err(o_err), .o_timeout(o_timeout),
        .o_rd_en(o_rd_en), .o_base_addr(o_base_addr), .o_offset_addr(o_offset_addr),
        .o_len(o_len), .o_obj_error(o_obj_error), .i_read_done(i_read_done),
        .i_read_error(i_read_error), .o_busy(o_busy)
    );

    // kind: 0 engine done, 1 engine error, 2 done and error together
    typedef struct {
        logic [N-1:0]  req;
        logic [AW-1:0] base, off, len;
        int            kind, dly;
        bit            early;
        logic [N-1:0]  gnt;
        logic [AW-1:0] ebase, eoff;
        bit            eobj;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] all_out();
        return {o_grant, o_done, o_err, o_timeout, o_rd_en, o_obj_error, o_busy,
                o_base_addr, o_offset_addr, o_len};
    endfunction

    // requester k sees base + k*0x1000, offset + k, and the shared length
    task automatic drive(input vec_t v);
        for (int k = 0; k < N; k++) begin
            i_base_addr[k*AW +: AW] = v.base + AW'(k * 16'h1000);
            i_offset_addr[k*AW +: AW] = v.off + AW'(k);
            i_len[k*AW +: AW] = v.len;
        end
        i_req = v.req;
    endtask

    task automatic run_txn(input vec_t v, input int id);
        logic [N-1:0] edone, eerr;
        edone = (v.kind == 0) ? v.gnt : '0;
        eerr = (v.kind != 0) ? v.gnt : '0;
        drive(v);
        @(negedge i_clk);
        chk($sformatf("v%0d grant", id), 64'(o_grant), 64'(v.gnt));
        chk($sformatf("v%0d rd_en", id), 64'(o_rd_en), 64'(1));
        chk($sformatf("v%0d base", id), 64'(o_base_addr), 64'(v.ebase));
        chk($sformatf("v%0d offset", id), 64'(o_offset_addr), 64'(v.eoff));
        chk($sformatf("v%0d len", id), 64'(o_len), 64'(v.len));
        chk($sformatf("v%0d obj_error", id), 64'(o_obj_error), 64'(v.eobj));
        chk($sformatf("v%0d busy", id), 64'(o_busy), 64'(1));
        if (v.early) i_read_done = 1'b1;
        @(negedge i_clk);
        i_read_done = 1'b0;
        chk($sformatf("v%0d rd_en drop", id), 64'(o_rd_en), 64'(0));
        chk($sformatf("v%0d grant held", id), 64'({o_grant, o_done, o_err}), 64'({v.gnt, 8'h00}));
        repeat (v.dly) @(negedge i_clk);
        i_read_done = (v.kind != 1);
        i_read_error = (v.kind != 0);
        @(negedge i_clk);
        i_read_done = 1'b0;
        i_read_error = 1'b0;
        i_req = '0;
        chk($sformatf("v%0d done", id), 64'(o_done), 64'(edone));
        chk($sformatf("v%0d err", id), 64'(o_err), 64'(eerr));
        chk($sformatf("v%0d release", id), 64'({o_timeout, o_grant, o_obj_error}), 64'(0));
        @(negedge i_clk);
        chk($sformatf("v%0d idle", id), 64'({o_busy, o_done, o_err}), 64'(0));
    endtask

    initial begin
        vec_t tv;
        bit early_hit;
        vecs[0]  = '{4'b0001, 16'h0100, 16'h0020, 16'd8,      0, 11, 1'b0, 4'b0001, 16'h0100, 16'h0020, 1'b0};
        vecs[1]  = '{4'b1111, 16'h0200, 16'h0040, 16'd16,     0, 2,  1'b0, 4'b0010, 16'h1200, 16'h0041, 1'b0};
        vecs[2]  = '{4'b1111, 16'h0200, 16'h0040, 16'd16,     0, 2,  1'b0, 4'b0100, 16'h2200, 16'h0042, 1'b0};
        vecs[3]  = '{4'b1111, 16'h0200, 16'h0040, 16'd16,     0, 2,  1'b0, 4'b1000, 16'h3200, 16'h0043, 1'b0};
        vecs[4]  = '{4'b1111, 16'h0200, 16'h0040, 16'd16,     0, 2,  1'b0, 4'b0001, 16'h0200, 16'h0040, 1'b0};
        vecs[5]  = '{4'b0101, 16'h0200, 16'h0040, 16'd16,     0, 0,  1'b0, 4'b0100, 16'h2200, 16'h0042, 1'b0};
        vecs[6]  = '{4'b0100, 16'h0300, 16'h0010, 16'd0,      1, 3,  1'b0, 4'b0100, 16'h2300, 16'h0012, 1'b1};
        vecs[7]  = '{4'b0100, 16'h0300, 16'h0010, 16'd300,    1, 3,  1'b0, 4'b0100, 16'h2300, 16'h0012, 1'b1};
        vecs[8]  = '{4'b0100, 16'h0300, 16'h0010, 16'd256,    0, 1,  1'b0, 4'b0100, 16'h2300, 16'h0012, 1'b0};
        vecs[9]  = '{4'b0100, 16'h0300, 16'h0010, 16'd257,    1, 1,  1'b0, 4'b0100, 16'h2300, 16'h0012, 1'b1};
        vecs[10] = '{4'b0010, 16'h0400, 16'h0001, 16'hFFFF,   1, 1,  1'b0, 4'b0010, 16'h1400, 16'h0002, 1'b1};
        vecs[11] = '{4'b1010, 16'h0500, 16'h0005, 16'd1,      2, 1,  1'b0, 4'b1000, 16'h3500, 16'h0008, 1'b0};
        vecs[12] = '{4'b1001, 16'h0600, 16'h0006, 16'd1,      0, 1,  1'b0, 4'b0001, 16'h0600, 16'h0006, 1'b0};
        vecs[13] = '{4'b0001, 16'h0700, 16'h0007, 16'd4,      0, 2,  1'b1, 4'b0001, 16'h0700, 16'h0007, 1'b0};

        repeat (2) @(negedge i_clk);
        chk("reset outputs", all_out(), 64'(0));
        i_rst_n = 1'b1;
        for (int i = 0; i < 14; i++) run_txn(vecs[i], i);

        // engine never answers: timeout 16 cycles after WAIT entry, late done dropped
        tv = '{4'b0010, 16'h0800, 16'h0008, 16'd32, 0, 0, 1'b0, 4'b0010, 16'h1800, 16'h0009, 1'b0};
        drive(tv);
        @(negedge i_clk);
        chk("tmo grant", 64'({o_grant, o_rd_en}), 64'({4'b0010, 1'b1}));
        @(negedge i_clk);
        early_hit = 1'b0;
        for (int c = 1; c < 16; c++) begin
            @(negedge i_clk);
            if ((o_err | o_done) != '0 || o_timeout || o_grant != 4'b0010) early_hit = 1'b1;
        end
        chk("tmo not early", 64'(early_hit), 64'(0));
        @(negedge i_clk);
        chk("tmo err", 64'(o_err), 64'(4'b0010));
        chk("tmo flag", 64'(o_timeout), 64'(1));
        chk("tmo release", 64'({o_grant, o_done}), 64'(0));
        i_req = '0;
        i_read_done = 1'b1;
        @(negedge i_clk);
        chk("tmo late done", 64'({o_done, o_err, o_timeout, o_busy}), 64'(0));
        @(negedge i_clk);
        i_read_done = 1'b0;
        chk("tmo late done idle", 64'({o_done, o_err, o_grant, o_busy}), 64'(0));
        tv = '{4'b0100, 16'h0900, 16'h0009, 16'd2, 0, 1, 1'b0, 4'b0100, 16'h2900, 16'h000B, 1'b0};
        run_txn(tv, 14);

        // asynchronous reset while in WAIT
        tv = '{4'b0001, 16'h0A00, 16'h000A, 16'd8, 0, 0, 1'b0, 4'b0001, 16'h0A00, 16'h000A, 1'b0};
        drive(tv);
        @(negedge i_clk);
        chk("rst grant", 64'(o_grant), 64'(4'b0001));
        @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1 chk("rst async clear", all_out(), 64'(0));
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_req = 4'b1001;
        @(negedge i_clk);
        chk("rst regrant", 64'({o_grant, o_rd_en}), 64'({4'b0001, 1'b1}));
        chk("rst regrant base", 64'(o_base_addr), 64'(16'h0A00));
        i_req = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
